data_memory_mmio: RTL
=====================

# data_memory_mmio

Parametrised data memory for the pipelined ARMv8 core's MEM stage, with a memory-mapped I/O window. It provides word-addressed RAM with registered one-cycle read latency. Its MMIO registers cover debounced board switches, a writable LED register, a free-running cycle counter and a sticky bus-error flag. It sits between the EX/MEM pipeline register and the MEM/WB register; the LED outputs go straight to board pins.

## Interface
- WORDS, 8192, RAM depth in 64-bit words
- ADDR_BITS, 13, RAM word-index width (2^ADDR_BITS ≥ WORDS)
- DATA_W, 64, data width
- SW_W, 18, switch count
- LED_W, 27, LED count
- DEBOUNCE_CYCLES, 16, stable cycles required before a switch change is accepted (≥ 2)
- clock  in  1  sole clock, rising-edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  64  word address; region select = address[31:15], offset = address[ADDR_BITS-1:0]
- write_data  in  DATA_W  store data
- MemWrite  in  1  store strobe, sampled on rising edge
- MemRead  in  1  load strobe, sampled on rising edge
- switches  in  SW_W  raw, asynchronous board switches
- read_data  out  DATA_W  load result, registered
- read_valid  out  1  high for exactly one cycle when read_data carries a new load result
- leds  out  LED_W  LED register contents
- bus_error  out  1  sticky error flag

## Operation
- Region 0 (address[31:15]==0) is RAM.
  - Offset < WORDS: store writes RAM; load returns RAM word.
  - Offset ≥ WORDS: store ignored; load returns 0; bus_error set.
- Region 1 (address[31:15]==1) is MMIO, decoded on address[2:0] (higher offset bits ignored).
  - 0: switch state. Read-only; zero-extended debounced switches. Store ignored, sets bus_error.
  - 1: LED register. Read/write; store loads write_data[LED_W-1:0]; load returns the zero-extended LED register.
  - 2: cycle counter. Read-only 64-bit free-running count, increments every cycle, wraps 2^64-1 → 0. Store ignored, sets bus_error.
  - 3: error status. Load returns {63'b0, bus_error}; any store clears bus_error.
  - 4–7: reserved. Load returns 0, store ignored; both set bus_error.
- Any other region: load returns 0, store ignored, both set bus_error.
- MemRead and MemWrite together on the same address: read-before-write. read_data returns the old value; the new value is visible to the next load.
- A store to offset 3 coinciding with a new error event: clear wins.
- Switch debounce:
  - A two-flop synchroniser feeds a shared stability counter.
  - The counter resets to 0 whenever the synchronised vector changes between cycles.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the synchronised vector differs from the debounced register, the debounced register loads the whole vector.
  - The counter saturates at DEBOUNCE_CYCLES-1.

## Timing
- Load latency is 1 cycle. With MemRead high at edge N, read_data and read_valid=1 appear after edge N; read_valid drops after edge N+1 unless MemRead is still high.
- read_data holds its last value while MemRead is low.
- Store latency: RAM or LED register updated at the edge that samples MemWrite.
- leds changes on the edge after the store; no combinational path from inputs to leds.
- Switch latency: 2 synchroniser cycles + DEBOUNCE_CYCLES from a stable input change to a visible offset-0 value.
- Reset values: read_data=0, read_valid=0, leds=0, bus_error=0, cycle counter=0, debounced switches=0, stability counter=0, synchronisers=0.
- RAM contents are not reset.
- Reset asserted mid-operation: all of the above clear immediately (asynchronous). A load in flight produces no read_valid. The first increment happens at the first edge after reset_n rises.

## Structure
- Shared package holds:
  - the region constants: RAM=17'h0, MMIO=17'h1
  - the MMIO offset constants: SW=0, LED=1, CYCLE=2, ERR=3
- Sub-module `switch_debouncer` (params WIDTH, DEBOUNCE_CYCLES; ports clock, reset_n, raw, debounced) contains the synchroniser and stability counter.
- The top level holds the RAM array, decode, LED/error/cycle registers and the read mux.

## Test plan
- Reset, then store 64'hDEADBEEF_CAFEF00D to address 5, then load address 5 → read_data=64'hDEADBEEF_CAFEF00D with read_valid=1 one cycle after MemRead; read_valid=0 the following idle cycle.
- Simultaneous MemRead+MemWrite at address 7 (old 64'h1, new 64'h2) → read_data=64'h1; next load at address 7 → 64'h2.
- Store 64'h5A5A5A5 to MMIO offset 1 (address 32'h8001) → leds=27'h5A5A5A5 after the edge; load offset 1 returns 64'h5A5A5A5.
- switches 18'h3FFFF with a 1-cycle glitch to 0 during settling → offset 0 reads 0 until 2+16 stable cycles have elapsed, then 64'h3FFFF.
- Load address 32'h8000+8192 (region 1, offset 0) vs RAM offset 8192 → read_data=0, bus_error=1. A store to 32'h8003 clears it the next cycle, and offset 3 then reads 0.
- Assert reset_n low during a load → read_valid=0 and read_data=0 immediately. Cycle counter reads 0, then increments by 1 per cycle after release.

Source files
------------

// File: rtl/data_memory_mmio_pkg.sv
// Shared definitions for the MEM-stage data memory with its MMIO window.
// Holds the region selects (address[31:15]), the MMIO register offsets
// (address[2:0]) and the per-access side-effect bundle the top decodes into.
package data_memory_mmio_pkg;

  localparam logic [16:0] REGION_RAM  = 17'h0;
  localparam logic [16:0] REGION_MMIO = 17'h1;

  localparam logic [2:0] MMIO_SW    = 3'd0;
  localparam logic [2:0] MMIO_LED   = 3'd1;
  localparam logic [2:0] MMIO_CYCLE = 3'd2;
  localparam logic [2:0] MMIO_ERR   = 3'd3;

  // State changes caused by the access presented this cycle.
  typedef struct packed {
    logic ram_write;
    logic led_write;
    logic err_clear;
    logic err_event;
  } access_effects_t;

endpackage

// File: rtl/data_memory_mmio_switch_debouncer.sv
// Debouncer for the raw board switches.
// A two-flop synchroniser feeds one stability counter shared by all bits. The
// counter restarts whenever the synchronised vector changes. Once it has
// saturated at DEBOUNCE_CYCLES-1, the whole synchronised vector is copied to
// the debounced output.
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   raw        asynchronous switch inputs
//   debounced  accepted switch state
module switch_debouncer #(
  parameter int WIDTH           = 18,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] debounced
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_q;
  logic [CNT_W-1:0] stable_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta    <= '0;
      sync_q       <= '0;
      stable_count <= '0;
      debounced    <= '0;
    end else begin
      // NOTE: non-blocking assignments make every comparison below see the
      // pre-edge values, so the shift chain and counter advance in lockstep.
      sync_meta <= raw;
      sync_q    <= sync_meta;

      // sync_meta is the value sync_q is about to take: a mismatch means the
      // synchronised vector changes at this edge.
      if (sync_meta != sync_q) begin
        stable_count <= '0;
      end else if (stable_count != CNT_MAX) begin
        stable_count <= stable_count + CNT_W'(1);
      end

      if (stable_count == CNT_MAX && sync_q != debounced) begin
        debounced <= sync_q;
      end
    end
  end

endmodule

// File: rtl/data_memory_mmio.sv
// Data memory for the MEM stage of the pipelined ARMv8 core.
// Region 0 is word-addressed RAM; region 1 is an MMIO window with switches,
// LED register, free-running cycle counter and a sticky bus-error flag.
// Loads have one cycle of registered latency; a load and store in the same
// cycle return the old contents.
// Ports:
//   clock, reset_n      clock and asynchronous active-low reset
//   address             word address; region = [31:15], offset below that
//   write_data          store data
//   MemWrite, MemRead   store / load strobes
//   switches            raw board switches
//   read_data           registered load result, held while no load
//   read_valid          one-cycle pulse per load result
//   leds                LED register, straight to pins
//   bus_error           sticky error flag, cleared by any store to offset 3
module data_memory_mmio
  import data_memory_mmio_pkg::*;
#(
  parameter int WORDS           = 8192,
  parameter int ADDR_BITS       = 13,
  parameter int DATA_W          = 64,
  parameter int SW_W            = 18,
  parameter int LED_W           = 27,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [63:0]       address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [SW_W-1:0]   switches,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic [LED_W-1:0]  leds,
  output logic              bus_error
);

  logic [DATA_W-1:0] ram [WORDS];

  logic [16:0]          region;
  logic [14:0]          region_offset;
  logic [ADDR_BITS-1:0] word_index;
  logic [2:0]           mmio_sel;
  logic                 ram_in_range;
  logic                 unused_address_bits;

  logic [SW_W-1:0]   switches_db;
  logic [LED_W-1:0]  led_reg;
  logic [63:0]       cycle_count;

  logic [DATA_W-1:0] load_value;
  logic              load_err;
  logic              store_err;
  access_effects_t   fx;

  assign region        = address[31:15];
  assign region_offset = address[14:0];
  assign word_index    = address[ADDR_BITS-1:0];
  assign mmio_sel      = address[2:0];
  // The upper half of the 64-bit address does not take part in decode.
  assign unused_address_bits = ^address[63:32];

  // Range check uses the whole region offset, so RAM aliases are caught as
  // errors instead of silently wrapping onto low words.
  assign ram_in_range = {17'b0, region_offset} < 32'(WORDS);

  switch_debouncer #(
    .WIDTH           (SW_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_switch_debouncer (
    .clock     (clock),
    .reset_n   (reset_n),
    .raw       (switches),
    .debounced (switches_db)
  );

  // Read mux and error classification for the current address.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    load_value = '0;
    load_err   = 1'b0;
    store_err  = 1'b0;
    case (region)
      REGION_RAM: begin
        if (ram_in_range) begin
          load_value = ram[word_index];
        end else begin
          load_err  = 1'b1;
          store_err = 1'b1;
        end
      end
      REGION_MMIO: begin
        case (mmio_sel)
          MMIO_SW: begin
            load_value = DATA_W'(switches_db);
            store_err  = 1'b1;
          end
          MMIO_LED:   load_value = DATA_W'(led_reg);
          MMIO_CYCLE: begin
            load_value = DATA_W'(cycle_count);
            store_err  = 1'b1;
          end
          MMIO_ERR:   load_value = DATA_W'(bus_error);
          default: begin
            load_err  = 1'b1;
            store_err = 1'b1;
          end
        endcase
      end
      default: begin
        load_err  = 1'b1;
        store_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    fx.ram_write = MemWrite && region == REGION_RAM && ram_in_range;
    fx.led_write = MemWrite && region == REGION_MMIO && mmio_sel == MMIO_LED;
    fx.err_clear = MemWrite && region == REGION_MMIO && mmio_sel == MMIO_ERR;
    fx.err_event = (MemRead && load_err) || (MemWrite && store_err);
  end

  // NOTE: the RAM array is deliberately left out of reset so it can map onto
  // block RAM; its contents are undefined until written.
  always_ff @(posedge clock) begin
    if (fx.ram_write) begin
      ram[word_index] <= write_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_data   <= '0;
      read_valid  <= 1'b0;
      led_reg     <= '0;
      bus_error   <= 1'b0;
      cycle_count <= '0;
    end else begin
      // load_value is formed from pre-edge state, which gives read-before-
      // write when a load and a store hit the same location.
      read_valid <= MemRead;
      if (MemRead) begin
        read_data <= load_value;
      end

      if (fx.led_write) begin
        led_reg <= write_data[LED_W-1:0];
      end

      // Clearing takes priority over an error raised in the same cycle.
      if (fx.err_clear) begin
        bus_error <= 1'b0;
      end else if (fx.err_event) begin
        bus_error <= 1'b1;
      end

      cycle_count <= cycle_count + 64'd1;
    end
  end

  assign leds = led_reg;

endmodule
